freq_meter: RTL and testbench

Measures the frequency of a slow square-wave signal, such as the output of the clock divider stage, by counting its rising edges over a programmable gate window of system-clock cycles. It sits directly downstream of the divider. It synchronises the divided signal into the `clk` domain, counts edges while the gate is open, then presents the result on a valid/ready handshake to the consuming logic.

---
 rtl/freq_meter.sv | 99 +++++++++
 tb/tb_freq_meter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated edge counter: synchronises a slow square wave into clk, counts its rising
// edges over a gate of gate_len clk cycles and offers the result on valid/ready.
module freq_meter #(
  parameter int COUNT_WIDTH = 16,
  parameter int GATE_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sig_in,
  input  logic                   start,
  input  logic [GATE_WIDTH-1:0]  gate_len,
  input  logic                   ready,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   valid,
  output logic                   busy,
  output logic                   overflow,
  output logic [1:0]             dbg_state
);

  // Handshake: the result is offered while valid=1 and count/overflow are held;
  // it is consumed at the first rising edge where valid=1 and ready=1.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [GATE_WIDTH-1:0]  gate_q, gate_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   s1_q, s2_q, s3_q;
  logic                   rise;

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (gate_len != '0)) begin
          gate_d  = gate_len;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // Saturate rather than wrap so a too-fast input is never under-reported.
        if (rise) begin
          if (count_q != '1) count_d = count_q + 1'b1;
          else               ovf_d   = 1'b1;
        end
        gate_d = gate_q - 1'b1;
        if (gate_q == GATE_WIDTH'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == ST_MEASURE);
  assign valid     = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 16-bit instance for the main cases and a
// 4-bit instance for count saturation, sharing clock, reset and sig_in.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gate_len = '0;
  logic        ready = 1'b0;
  logic [15:0] count;
  logic        valid, busy, overflow;
  logic [1:0]  dbg_state;

  logic        start_s = 1'b0;
  logic [15:0] gate_s = '0;
  logic        ready_s = 1'b0;
  logic [3:0]  count_s;
  logic        valid_s, busy_s, overflow_s;
  logic [1:0]  dbg_state_s;

  int errors = 0;
  int checks = 0;
  int per = 2;
  int ph = 0;

  always #5 clk = ~clk;

  freq_meter #(.COUNT_WIDTH(16), .GATE_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start), .gate_len(gate_len),
    .ready(ready), .count(count), .valid(valid), .busy(busy), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  freq_meter #(.COUNT_WIDTH(4), .GATE_WIDTH(16)) u_sat (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start_s), .gate_len(gate_s),
    .ready(ready_s), .count(count_s), .valid(valid_s), .busy(busy_s), .overflow(overflow_s),
    .dbg_state(dbg_state_s)
  );

  // Square-wave source: period 'per' clk cycles, high for the first half.
  initial begin
    forever begin
      @(negedge clk);
      if (per == 0) sig_in = 1'b0;
      else begin
        ph = (ph + 1) % per;
        sig_in = (ph < per / 2);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int n;
  logic seen;

  initial begin
    // Reset held with start asserted and sig_in toggling.
    per = 2;
    start = 1'b1; gate_len = 16'd5;
    start_s = 1'b1; gate_s = 16'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_count", count, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_sat_busy", busy_s, 0);
    end
    start = 1'b0; start_s = 1'b0;
    reset = 1'b1;
    repeat (5) tick();

    // Period-2 input, 100-cycle gate.
    start = 1'b1; gate_len = 16'd100;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin n++; tick(); end
    chk("p2_busy_len", n, 100);
    chk("p2_valid", valid, 1);
    chk("p2_count", count, 50);
    chk("p2_ovf", overflow, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("p2_accept", valid, 0);

    // Period-8 input, 64-cycle gate, delayed ready and ignored start.
    per = 8; ph = 0;
    repeat (12) tick();
    start = 1'b1; gate_len = 16'd64;
    tick();
    start = 1'b0;
    n = 0;
    while (!valid && n < 200) begin n++; tick(); end
    chk("p8_latency", n, 64);
    for (int i = 0; i < 10; i++) begin
      chk("p8_hold_count", count, 8);
      chk("p8_hold_valid", valid, 1);
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      tick();
    end
    chk("p8_start_in_done", busy, 0);
    ready = 1'b1; start = 1'b1;
    tick();
    ready = 1'b0; start = 1'b0;
    chk("p8_valid_drop", valid, 0);
    chk("p8_no_restart", busy, 0);
    tick();
    chk("p8_idle_after", busy, 0);

    // Abort by reset at window cycle 20.
    per = 2; ph = 0;
    repeat (6) tick();
    start = 1'b1; gate_len = 16'd100;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("abort_busy_pre", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_count", count, 0);
    seen = 1'b0;
    for (int i = 0; i < 110; i++) begin
      if (valid || busy) seen = 1'b1;
      tick();
    end
    chk("abort_no_valid", seen, 0);

    // Zero gate is ignored.
    start = 1'b1; gate_len = 16'd0;
    tick();
    start = 1'b0;
    chk("zero_busy", busy, 0);
    chk("zero_valid", valid, 0);
    tick();
    chk("zero_busy2", busy, 0);

    // One-cycle gate.
    start = 1'b1; gate_len = 16'd1;
    tick();
    start = 1'b0;
    chk("g1_busy", busy, 1);
    chk("g1_valid_early", valid, 0);
    tick();
    chk("g1_valid", valid, 1);
    chk("g1_count_le1", (count <= 16'd1), 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("g1_accept", valid, 0);

    // Saturation on the 4-bit instance, then a clean run.
    start_s = 1'b1; gate_s = 16'd40;
    tick();
    start_s = 1'b0;
    n = 0;
    while (!valid_s && n < 100) begin n++; tick(); end
    chk("sat_latency", n, 40);
    chk("sat_count", count_s, 15);
    chk("sat_ovf", overflow_s, 1);
    ready_s = 1'b1;
    tick();
    ready_s = 1'b0;
    chk("sat_accept", valid_s, 0);
    start_s = 1'b1; gate_s = 16'd10;
    tick();
    start_s = 1'b0;
    chk("sat2_ovf_clear", overflow_s, 0);
    n = 0;
    while (!valid_s && n < 100) begin n++; tick(); end
    chk("sat2_latency", n, 10);
    chk("sat2_count", count_s, 5);
    chk("sat2_ovf", overflow_s, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
